// File: rtl/catch_possession_ctrl_pkg.sv
// Shared encodings for the catch-game possession controller and its helpers.
package catch_possession_ctrl_pkg;

    typedef enum logic [2:0] {
        PhServeWait = 3'd0,
        PhFree      = 3'd1,
        PhHeld1     = 3'd2,
        PhHeld2     = 3'd3,
        PhDropped   = 3'd4,
        PhGameOver  = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnG1   = 2'd1,
        OwnG2   = 2'd2
    } owner_e;

    localparam int unsigned PASS_W = 8;
    localparam int unsigned DROP_W = 4;

    function automatic logic [PASS_W-1:0] sat_inc(input logic [PASS_W-1:0] v);
        return (v == '1) ? v : v + PASS_W'(1);
    endfunction

endpackage

// File: rtl/catch_possession_ctrl_if.sv
// Glove/ball inputs and possession outputs of the catch controller.
interface catch_possession_ctrl_if;
    import catch_possession_ctrl_pkg::*;

    logic              i_vsync;
    logic              i_glove1closed;
    logic              i_glove2closed;
    logic              i_can_catch1;
    logic              i_can_catch2;
    logic              i_ball_landed;
    logic [1:0]        o_owner;
    logic              o_serve;
    logic              o_release;
    logic              o_foul;
    logic [PASS_W-1:0] o_pass_count;
    logic [DROP_W-1:0] o_drop_count;
    logic [2:0]        o_phase;

    modport master (
        output i_vsync, i_glove1closed, i_glove2closed, i_can_catch1, i_can_catch2,
               i_ball_landed,
        input  o_owner, o_serve, o_release, o_foul, o_pass_count, o_drop_count, o_phase
    );

    modport slave (
        input  i_vsync, i_glove1closed, i_glove2closed, i_can_catch1, i_can_catch2,
               i_ball_landed,
        output o_owner, o_serve, o_release, o_foul, o_pass_count, o_drop_count, o_phase
    );

endinterface

// File: rtl/catch_possession_ctrl_frame_tick_gen.sv
// One-cycle frame tick on the falling edge of the active-low vsync.
module frame_tick_gen (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_vsync,
    output logic o_tick
);

    logic r_vsync_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vsync_prev <= 1'b1;
        end else begin
            r_vsync_prev <= i_vsync;
        end
    end

    // Masked by reset so an edge coinciding with reset is lost, not deferred.
    assign o_tick = r_vsync_prev & ~i_vsync & ~i_reset;

endmodule

// File: rtl/catch_possession_ctrl.sv
// Round sequencer for the two-glove catch game: serve, grant, forced release, pass/drop counts.
module catch_possession_ctrl
    import catch_possession_ctrl_pkg::*;
#(
    parameter int unsigned SERVE_FRAMES    = 60,
    parameter int unsigned MAX_HOLD_FRAMES = 180,
    parameter int unsigned MAX_DROPS       = 3,
    parameter int unsigned FCNT_W          = 8
) (
    input  logic                    i_vclock,
    input  logic                    i_reset,
    catch_possession_ctrl_if.slave  bus
);

    localparam logic [FCNT_W-1:0] SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
    localparam logic [FCNT_W-1:0] HOLD_LAST  = FCNT_W'(MAX_HOLD_FRAMES - 1);
    localparam logic [DROP_W-1:0] DROP_LIMIT = DROP_W'(MAX_DROPS);

    logic              w_tick;
    logic              w_req1;
    logic              w_req2;
    logic              w_hold_closed;
    logic              r_g1_prev;
    logic              r_g2_prev;
    phase_e            r_phase;
    phase_e            w_phase_d;
    owner_e            r_owner;
    owner_e            w_owner_d;
    owner_e            r_last;
    owner_e            w_last_d;
    owner_e            w_grant;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_d;
    logic              r_serve;
    logic              w_serve_d;
    logic              r_release;
    logic              w_release_d;
    logic              r_foul;
    logic              w_foul_d;
    logic [PASS_W-1:0] r_pass;
    logic [PASS_W-1:0] w_pass_d;
    logic [DROP_W-1:0] r_drop;
    logic [DROP_W-1:0] w_drop_d;
    logic [DROP_W-1:0] w_drop_inc;

    frame_tick_gen u_frame_tick (
        .i_clk   (i_vclock),
        .i_reset (i_reset),
        .i_vsync (bus.i_vsync),
        .o_tick  (w_tick)
    );

    // A glove already closed cannot grab: only a fresh closure counts.
    assign w_req1 = bus.i_glove1closed & ~r_g1_prev & bus.i_can_catch1;
    assign w_req2 = bus.i_glove2closed & ~r_g2_prev & bus.i_can_catch2;

    always_comb begin
        w_phase_d     = r_phase;
        w_owner_d     = r_owner;
        w_last_d      = r_last;
        w_fcnt_d      = r_fcnt;
        w_serve_d     = 1'b0;
        w_release_d   = 1'b0;
        w_foul_d      = 1'b0;
        w_pass_d      = r_pass;
        w_drop_d      = r_drop;
        w_grant       = OwnNone;
        w_hold_closed = 1'b0;
        w_drop_inc    = r_drop + DROP_W'(1);

        unique case (r_phase)
            PhServeWait: begin
                if (w_tick) begin
                    if (r_fcnt == SERVE_LAST) begin
                        w_serve_d = 1'b1;
                        w_fcnt_d  = '0;
                        w_phase_d = PhFree;
                    end else begin
                        w_fcnt_d = r_fcnt + FCNT_W'(1);
                    end
                end
            end
            PhFree: begin
                // Simultaneous grabs go to whoever did not hold it last.
                if (w_req1 && w_req2) begin
                    w_grant = (r_last == OwnG1) ? OwnG2 : OwnG1;
                end else if (w_req1) begin
                    w_grant = OwnG1;
                end else if (w_req2) begin
                    w_grant = OwnG2;
                end
                if (w_grant != OwnNone) begin
                    w_owner_d = w_grant;
                    w_phase_d = (w_grant == OwnG1) ? PhHeld1 : PhHeld2;
                    if (r_last != OwnNone && r_last != w_grant) begin
                        w_pass_d = sat_inc(r_pass);
                    end
                end else if (bus.i_ball_landed) begin
                    w_phase_d = PhDropped;
                end
            end
            PhHeld1, PhHeld2: begin
                w_hold_closed = (r_phase == PhHeld1) ? bus.i_glove1closed : bus.i_glove2closed;
                if (!w_hold_closed || (w_tick && r_fcnt == HOLD_LAST)) begin
                    w_release_d = 1'b1;
                    w_foul_d    = w_hold_closed;
                    w_last_d    = r_owner;
                    w_owner_d   = OwnNone;
                    w_fcnt_d    = '0;
                    w_phase_d   = PhFree;
                end else if (w_tick) begin
                    w_fcnt_d = r_fcnt + FCNT_W'(1);
                end
            end
            PhDropped: begin
                w_drop_d  = w_drop_inc;
                w_last_d  = OwnNone;
                w_fcnt_d  = '0;
                w_phase_d = (w_drop_inc == DROP_LIMIT) ? PhGameOver : PhServeWait;
            end
            PhGameOver: begin
            end
            default: begin
                w_phase_d = PhServeWait;
            end
        endcase
    end

    always_ff @(posedge i_vclock) begin
        if (i_reset) begin
            r_phase   <= PhServeWait;
            r_owner   <= OwnNone;
            r_last    <= OwnNone;
            r_fcnt    <= '0;
            r_serve   <= 1'b0;
            r_release <= 1'b0;
            r_foul    <= 1'b0;
            r_pass    <= '0;
            r_drop    <= '0;
            r_g1_prev <= 1'b0;
            r_g2_prev <= 1'b0;
        end else begin
            r_phase   <= w_phase_d;
            r_owner   <= w_owner_d;
            r_last    <= w_last_d;
            r_fcnt    <= w_fcnt_d;
            r_serve   <= w_serve_d;
            r_release <= w_release_d;
            r_foul    <= w_foul_d;
            r_pass    <= w_pass_d;
            r_drop    <= w_drop_d;
            r_g1_prev <= bus.i_glove1closed;
            r_g2_prev <= bus.i_glove2closed;
        end
    end

    assign bus.o_owner      = r_owner;
    assign bus.o_serve      = r_serve;
    assign bus.o_release    = r_release;
    assign bus.o_foul       = r_foul;
    assign bus.o_pass_count = r_pass;
    assign bus.o_drop_count = r_drop;
    assign bus.o_phase      = r_phase;

endmodule

// File: tb/tb_catch_possession_ctrl.sv
// Bench for catch_possession_ctrl: vector table, hand sequences and a random run vs. a game model.
module tb_catch_possession_ctrl;

    localparam int SERVE = 60;
    localparam int HOLD  = 180;
    localparam int DROPS = 3;

    // Game-level model modes.
    localparam int MW = 0;  // waiting to serve
    localparam int MF = 1;  // ball in flight
    localparam int MH = 2;  // ball held
    localparam int MD = 3;  // just dropped
    localparam int MO = 4;  // game over

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    int m_mode = MW, m_holder = 0, m_last = 0, m_frames = 0, m_passes = 0, m_drops = 0;
    bit m_vs = 1'b1, m_g1 = 1'b0, m_g2 = 1'b0;
    bit e_serve = 1'b0, e_rel = 1'b0, e_foul = 1'b0;

    typedef struct {
        bit g1, g2, c1, c2, land;
        int owner, phase;
        bit rel, foul;
        int pass, drop;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    catch_possession_ctrl_if bus ();

    catch_possession_ctrl #(
        .SERVE_FRAMES    (SERVE),
        .MAX_HOLD_FRAMES (HOLD),
        .MAX_DROPS       (DROPS),
        .FCNT_W          (8)
    ) dut (
        .i_vclock (clk),
        .i_reset  (rst),
        .bus      (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pack(input int owner, input int srv, input int rel, input int foul,
                                input int pass, input int drop, input int ph);
        return (owner << 17) | (srv << 16) | (rel << 15) | (foul << 14) | (pass << 6)
             | (drop << 3) | ph;
    endfunction

    function automatic int model_vec();
        int ph;
        case (m_mode)
            MW:      ph = 0;
            MF:      ph = 1;
            MH:      ph = 1 + m_holder;
            MD:      ph = 4;
            default: ph = 5;
        endcase
        return pack((m_mode == MH) ? m_holder : 0, e_serve, e_rel, e_foul, m_passes, m_drops, ph);
    endfunction

    function automatic int dut_vec();
        return pack(bus.o_owner, bus.o_serve, bus.o_release, bus.o_foul, bus.o_pass_count,
                    bus.o_drop_count, bus.o_phase);
    endfunction

    task automatic model_let_go(input bit forced);
        e_rel    = 1'b1;
        e_foul   = forced;
        m_last   = m_holder;
        m_holder = 0;
        m_frames = 0;
        m_mode   = MF;
    endtask

    // Advance the model across one clock edge using the inputs now on the bus.
    task automatic model_edge();
        bit tick, r1, r2, closed;
        int want;
        tick    = m_vs && !bus.i_vsync && !rst;
        r1      = bus.i_glove1closed && !m_g1 && bus.i_can_catch1;
        r2      = bus.i_glove2closed && !m_g2 && bus.i_can_catch2;
        e_serve = 1'b0;
        e_rel   = 1'b0;
        e_foul  = 1'b0;
        if (rst) begin
            m_mode = MW; m_holder = 0; m_last = 0; m_frames = 0; m_passes = 0; m_drops = 0;
            m_vs = 1'b1; m_g1 = 1'b0; m_g2 = 1'b0;
            return;
        end
        m_vs = bus.i_vsync;
        m_g1 = bus.i_glove1closed;
        m_g2 = bus.i_glove2closed;
        if (m_mode == MW) begin
            if (tick) m_frames++;
            if (m_frames == SERVE) begin
                e_serve  = 1'b1;
                m_frames = 0;
                m_mode   = MF;
            end
        end else if (m_mode == MF) begin
            if (r1 || r2) begin
                if (r1 && r2) want = (m_last == 1) ? 2 : 1;
                else          want = r1 ? 1 : 2;
                if (m_last != 0 && m_last != want && m_passes < 255) m_passes++;
                m_holder = want;
                m_mode   = MH;
            end else if (bus.i_ball_landed) begin
                m_mode = MD;
            end
        end else if (m_mode == MH) begin
            closed = (m_holder == 1) ? bus.i_glove1closed : bus.i_glove2closed;
            if (!closed) begin
                model_let_go(1'b0);
            end else if (tick) begin
                m_frames++;
                if (m_frames == HOLD) model_let_go(1'b1);
            end
        end else if (m_mode == MD) begin
            m_drops++;
            m_last   = 0;
            m_frames = 0;
            m_mode   = (m_drops == DROPS) ? MO : MW;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic set_inputs(input bit g1, input bit g2, input bit c1, input bit c2,
                              input bit land);
        bus.i_glove1closed = g1;
        bus.i_glove2closed = g2;
        bus.i_can_catch1   = c1;
        bus.i_can_catch2   = c2;
        bus.i_ball_landed  = land;
    endtask

    task automatic serve_and_check();
        int stray = 0;
        for (int i = 1; i <= SERVE; i++) begin
            bus.i_vsync = 1'b0;
            step();
            if (i == SERVE) begin
                check("serve_pulse", bus.o_serve, 1);
                check("serve_phase", bus.o_phase, 1);
                check("serve_owner", bus.o_owner, 0);
            end else if (bus.o_serve) begin
                stray++;
            end
            bus.i_vsync = 1'b1;
            step();
            if (bus.o_serve) stray++;
        end
        check("serve_stray_pulses", stray, 0);
    endtask

    // Holds for HOLD ticks; optionally opens the glove on the final tick.
    task automatic hold_to_limit(input int glove, input bit open_last);
        int stray = 0;
        for (int i = 1; i <= HOLD; i++) begin
            if (i == HOLD && open_last) begin
                if (glove == 1) bus.i_glove1closed = 1'b0;
                else            bus.i_glove2closed = 1'b0;
            end
            bus.i_vsync = 1'b0;
            step();
            if (i == HOLD) begin
                check("hold_release", bus.o_release, 1);
                check("hold_foul", bus.o_foul, open_last ? 0 : 1);
                check("hold_owner", bus.o_owner, 0);
                check("hold_phase", bus.o_phase, 1);
            end else if (bus.o_release) begin
                stray++;
            end
            bus.i_vsync = 1'b1;
            step();
            if (bus.o_release || bus.o_foul) stray++;
        end
        check("hold_stray_release", stray, 0);
    endtask

    initial begin
        bus.i_vsync = 1'b1;
        set_inputs(0, 0, 0, 0, 0);

        // Vectors from a fresh FREE state (last owner none, no passes, no drops).
        tbl.push_back('{1, 0, 1, 0, 0, 1, 2, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 0, 2, 3, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0});
        tbl.push_back('{1, 1, 1, 1, 0, 1, 2, 0, 0, 2, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0});
        tbl.push_back('{1, 1, 1, 1, 0, 2, 3, 0, 0, 3, 0});
        tbl.push_back('{1, 1, 1, 1, 1, 2, 3, 0, 0, 3, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 2, 3, 0, 0, 3, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 4, 0, 0, 3, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1});

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_phase", bus.o_phase, 0);
        check("rst_owner", bus.o_owner, 0);
        check("rst_pulses", {bus.o_serve, bus.o_release, bus.o_foul}, 0);
        check("rst_pass", bus.o_pass_count, 0);
        check("rst_drop", bus.o_drop_count, 0);

        serve_and_check();

        foreach (tbl[k]) begin
            set_inputs(tbl[k].g1, tbl[k].g2, tbl[k].c1, tbl[k].c2, tbl[k].land);
            step();
            check($sformatf("vec%0d_owner", k), bus.o_owner, tbl[k].owner);
            check($sformatf("vec%0d_phase", k), bus.o_phase, tbl[k].phase);
            check($sformatf("vec%0d_release", k), bus.o_release, tbl[k].rel);
            check($sformatf("vec%0d_foul", k), bus.o_foul, tbl[k].foul);
            check($sformatf("vec%0d_pass", k), bus.o_pass_count, tbl[k].pass);
            check($sformatf("vec%0d_drop", k), bus.o_drop_count, tbl[k].drop);
        end
        set_inputs(0, 0, 0, 0, 0);

        // Tie with no previous owner goes to glove 1.
        serve_and_check();
        set_inputs(1, 1, 1, 1, 0);
        step();
        check("tie_last0_owner", bus.o_owner, 1);
        check("tie_last0_pass", bus.o_pass_count, 3);
        set_inputs(1, 0, 0, 0, 0);
        step();

        // Forced release after the hold limit, then no re-grant while still closed.
        hold_to_limit(1, 1'b0);
        bus.i_can_catch1 = 1'b1;
        repeat (3) begin
            bus.i_vsync = 1'b0; step();
            bus.i_vsync = 1'b1; step();
        end
        check("no_regrant_owner", bus.o_owner, 0);

        // Glove opening on the limit tick is an ordinary release.
        set_inputs(0, 0, 0, 0, 0);
        step();
        set_inputs(0, 1, 0, 1, 0);
        step();
        check("g2_grant_owner", bus.o_owner, 2);
        check("g2_grant_pass", bus.o_pass_count, 4);
        bus.i_can_catch2 = 1'b0;
        hold_to_limit(2, 1'b1);

        // Two more drops end the game.
        set_inputs(0, 0, 0, 0, 1);
        step();
        check("drop2_phase_dropped", bus.o_phase, 4);
        bus.i_ball_landed = 1'b0;
        step();
        check("drop2_phase", bus.o_phase, 0);
        check("drop2_count", bus.o_drop_count, 2);
        serve_and_check();
        bus.i_ball_landed = 1'b1;
        step();
        bus.i_ball_landed = 1'b0;
        step();
        check("over_phase", bus.o_phase, 5);
        check("over_drop", bus.o_drop_count, 3);
        for (int i = 0; i < 60; i++) begin
            bus.i_vsync = 1'($urandom_range(0, 1));
            set_inputs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
            step();
        end
        check("over_frozen_phase", bus.o_phase, 5);
        check("over_frozen_owner", bus.o_owner, 0);
        check("over_frozen_pass", bus.o_pass_count, 4);
        check("over_frozen_drop", bus.o_drop_count, 3);

        // Reset while glove 2 holds the ball.
        bus.i_vsync = 1'b1;
        set_inputs(0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        serve_and_check();
        set_inputs(1, 0, 1, 0, 0); step();
        set_inputs(0, 0, 0, 0, 0); step();
        set_inputs(0, 1, 0, 1, 0); step();
        check("pre_rst_owner", bus.o_owner, 2);
        check("pre_rst_pass", bus.o_pass_count, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_owner", bus.o_owner, 0);
        check("mid_rst_pass", bus.o_pass_count, 0);
        check("mid_rst_phase", bus.o_phase, 0);
        set_inputs(0, 0, 0, 0, 0);

        // Random play; glove activity alternates between busy and sluggish stretches.
        for (int i = 0; i < 20000; i++) begin
            int span;
            span = ((i / 2000) % 2 == 1) ? 1023 : 15;
            rst = ($urandom_range(0, 1499) == 0);
            bus.i_vsync = 1'($urandom_range(0, 1));
            if ($urandom_range(0, span) == 0) bus.i_glove1closed = ~bus.i_glove1closed;
            if ($urandom_range(0, span) == 0) bus.i_glove2closed = ~bus.i_glove2closed;
            bus.i_can_catch1  = 1'($urandom_range(0, 1));
            bus.i_can_catch2  = 1'($urandom_range(0, 1));
            bus.i_ball_landed = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
